// File: rtl/mdu_defs.sv
// mdu_defs: shared op codes, FSM state encoding and op-class decode for the MDU.
// Op codes 7-10 are recognised as multiply-class only when MDU_MADD_EN is defined.
package mdu_defs;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    return op inside {OP_MULT, OP_MULTU};
`endif
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: IDLE/RUN sequencer with latency counter; done pulses during the last RUN cycle.
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic start,
  input  logic is_div,
  input  logic clk,
  input  logic reset,
  output logic busy,
  output logic done
);
  state_e state, nxt;
  logic [31:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (state == IDLE && start) ? (is_div ? 32'(DIV_CYCLES - 1) : 32'(MULT_CYCLES - 1))
             : (cnt != 0) ? cnt - 32'd1 : cnt;
    end
  always_comb
    nxt = (state == IDLE) ? (start ? RUN : IDLE) : (cnt == 0 ? IDLE : RUN);
  always_comb begin
    busy = state == RUN;
    done = state == RUN && cnt == 0;
  end
endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit with HI/LO registers and fixed-latency busy window.
// Defining MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 7-10).
module mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic start, done, wr, sm, sd;
  logic [3:0] op_q;
  logic [31:0] a, b, ma, mb, uq, ur, q, r;
  logic [63:0] prod, acc, res;
  assign start = !busy && (is_mul(mdu_op) || is_div(mdu_op));
  mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_ctrl (
    .start (start),
    .is_div(is_div(mdu_op)),
    .clk   (clk),
    .reset (reset),
    .busy  (busy),
    .done  (done)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q <= '0;
      a    <= '0;
      b    <= '0;
    end else if (start) begin
      op_q <= mdu_op;
      a    <= rs;
      b    <= rt;
    end
  // Signed divide runs on magnitudes; this also makes 0x80000000 / -1 wrap to 0x80000000.
  always_comb begin
    sm   = op_q inside {OP_MULT, OP_MADD, OP_MSUB};
    sd   = op_q == OP_DIV;
    prod = {sm ? {32{a[31]}} : 32'b0, a} * {sm ? {32{b[31]}} : 32'b0, b};
    ma   = (sd && a[31]) ? -a : a;
    mb   = (sd && b[31]) ? -b : b;
    uq   = (mb == 0) ? '0 : ma / mb;
    ur   = (mb == 0) ? '0 : ma % mb;
    q    = (sd && (a[31] ^ b[31])) ? -uq : uq;
    r    = (sd && a[31]) ? -ur : ur;
`ifdef MDU_MADD_EN
    acc  = op_q inside {OP_MADD, OP_MADDU} ? {hi, lo} + prod
         : op_q inside {OP_MSUB, OP_MSUBU} ? {hi, lo} - prod : prod;
`else
    acc  = prod;
`endif
    res  = is_div(op_q) ? {r, q} : acc;
    wr   = done && !(is_div(op_q) && b == 0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (wr) begin
      hi <= res[63:32];
      lo <= res[31:0];
    end else if (!busy && mdu_op == OP_MTHI) begin
      hi <= rs;
    end else if (!busy && mdu_op == OP_MTLO) begin
      lo <= rs;
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and random checks of mdu against an arithmetic reference model.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, busy;
  logic [3:0] mdu_op = '0;
  logic [31:0] rs = '0, rt = '0, hi, lo;
  logic [31:0] m_hi = '0, m_lo = '0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .mdu_op(mdu_op), .rs(rs), .rt(rt),
    .busy(busy), .hi(hi), .lo(lo)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return MC;
    if (op == 4'd3 || op == 4'd4) return DC;
    if (op >= 4'd7 && op <= 4'd10) return MADD ? MC : 0;
    return 0;
  endfunction

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = (op == 4'd1 || op == 4'd7 || op == 4'd9) ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
    case (op)
      4'd1, 4'd2: {m_hi, m_lo} = p;
      4'd3: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      4'd7, 4'd8: if (MADD) {m_hi, m_lo} = {m_hi, m_lo} + p;
      4'd9, 4'd10: if (MADD) {m_hi, m_lo} = {m_hi, m_lo} - p;
      default: ;
    endcase
  endtask

  // Called at a negedge: presents one op, checks every busy cycle, then the result.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = lat(op);
    mdu_op = op; rs = a; rt = b;
    model(op, a, b);
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mdu_op = '0;
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    mdu_op = '0;
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    logic [31:0] edges [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
    logic [3:0] op;
    logic [31:0] a, b;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    do_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3);
    chk("mult_hi_const", hi, 32'hFFFFFFFF);
    chk("mult_lo_const", lo, 32'hFFFFFFFA);
    do_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3);
    do_op("divu", 4'd4, 32'd100, 32'd7);
    chk("divu_lo_const", lo, 32'd14);
    chk("divu_hi_const", hi, 32'd2);
    do_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_lo_const", lo, 32'hFFFFFFFD);
    chk("div_hi_const", hi, 32'hFFFFFFFF);
    do_op("mtlo", 4'd6, 32'h1234, 32'd0);
    do_op("div0", 4'd3, 32'd5, 32'd0);
    chk("div0_lo_const", lo, 32'h1234);
    do_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("divovf_lo_const", lo, 32'h80000000);
    chk("divovf_hi_const", hi, 32'd0);

    mdu_op = 4'd1; rs = 32'h12345678; rt = 32'h9ABCDEF0;
    model(4'd1, 32'h12345678, 32'h9ABCDEF0);
    @(posedge clk);
    for (int i = 1; i <= MC; i++) begin
      @(negedge clk);
      mdu_op = (i == 2) ? 4'd5 : 4'd0;
      rs = (i == 2) ? 32'hDEAD : 32'h0;
      chk("mthi_busy", {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    mdu_op = '0;
    chk("mthi_ign_busy", {31'b0, busy}, 32'd0);
    chk("mthi_ign_hi", hi, m_hi);
    chk("mthi_ign_lo", lo, m_lo);

    mdu_op = 4'd3; rs = 32'd50; rt = 32'd3;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      mdu_op = '0;
      chk("rstrun_busy", {31'b0, busy}, 32'd1);
    end
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    chk("rstrun_busy0", {31'b0, busy}, 32'd0);
    chk("rstrun_hi", hi, 32'd0);
    chk("rstrun_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    chk("rstrun_after_busy", {31'b0, busy}, 32'd0);
    chk("rstrun_after_hi", hi, 32'd0);
    chk("rstrun_after_lo", lo, 32'd0);

    do_op("madd_mthi", 4'd5, 32'd0, 32'd0);
    do_op("madd_mtlo", 4'd6, 32'd10, 32'd0);
    do_op("madd", 4'd7, 32'd3, 32'd4);
    chk("madd_lo_const", lo, MADD ? 32'd22 : 32'd10);
    chk("madd_hi_const", hi, 32'd0);

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      do_op($sformatf("rand%0d_op%0d", k, op), op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration in cycles for multiply-class ops.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration in cycles for divide-class ops.
REQ-003 The port list SHALL be as follows, in this order:
- clk  input  1: single clock; all state updates on the rising edge.
- reset  input  1: asynchronous, active-high reset.
- mdu_op  input  4: operation code, with 0 = NONE.
- rs  input  32: first operand, or the MTHI/MTLO data.
- rt  input  32: second operand.
- busy  output  1: high while an op is in flight.
- hi  output  32: HI register contents.
- lo  output  32: LO register contents.

Function
REQ-004 mdu_op encoding SHALL be fixed as follows:
- 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU.
- Codes 11-15 are treated as NONE.
REQ-005 The FSM SHALL have two states, IDLE and RUN; busy SHALL be 1 exactly when the state is RUN.
REQ-006 When in IDLE and mdu_op is MULT-class (1,2,7-10) at edge T, the block SHALL:
- latch rs, rt and the op;
- enter RUN;
- hold busy=1 for exactly MULT_CYCLES cycles starting at T.
REQ-007 DIV/DIVU SHALL behave as in REQ-006, except busy is held for DIV_CYCLES cycles.
REQ-008 On the edge that ends the last RUN cycle, the block SHALL write hi/lo and return to IDLE in that same edge; new hi/lo SHALL be visible in the first cycle busy=0.
REQ-009 MULT SHALL compute {hi,lo} = signed 64-bit product; MULTU SHALL compute the unsigned 64-bit product.
REQ-010 DIV SHALL compute lo = signed quotient truncated toward zero and hi = remainder with the sign of the dividend; DIVU SHALL compute the unsigned quotient and remainder.
REQ-011 Divide by zero SHALL still run the full DIV_CYCLES but leave hi/lo unchanged.
REQ-012 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-013 MTHI/MTLO in IDLE SHALL write rs into hi/lo at the edge, with no busy cycle.
REQ-014 Any non-NONE mdu_op presented while busy=1 SHALL be ignored; the in-flight op and its latched operands are unaffected.
REQ-015 hi/lo SHALL change only at RUN completion, on MTHI/MTLO, or on reset.
REQ-016 All 64-bit arithmetic SHALL wrap modulo 2^64, with no overflow flag.

Reset
REQ-017 reset=1 SHALL asynchronously force the following:
- state = IDLE, busy = 0;
- hi = 0, lo = 0;
- latency counter and latched operands = 0.
REQ-018 Reset asserted mid-RUN SHALL abort the op, with no write of its result.
REQ-019 The first op SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-020 With macro MDU_MADD_EN defined, codes 7-10 SHALL be supported as follows:
- MADD: {hi,lo} += signed rs*rt.
- MADDU: {hi,lo} += unsigned rs*rt.
- MSUB: {hi,lo} -= signed rs*rt.
- MSUBU: {hi,lo} -= unsigned rs*rt.
- Accumulation uses the hi/lo values at completion time, with MULT_CYCLES latency.
REQ-021 Without MDU_MADD_EN, codes 7-10 SHALL be treated as NONE: no busy, and no state change.

Structure
REQ-022 The mdu_op codes and the IDLE/RUN state encodings SHALL live in a shared header/package (mdu_defs), so that the decoder and the stall logic use the same values.
REQ-023 The latency counter and IDLE/RUN FSM SHALL be a sub-module, mdu_ctrl, with:
- inputs: start, is_div, clk, reset;
- outputs: busy, done.
The datapath and hi/lo registers stay in mdu.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- MULT rs=0xFFFFFFFE, rt=3 at T -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU rs=100, rt=7 -> busy=1 for 10 cycles, then lo=14, hi=2. Then DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=5, rt=0 after MTLO 0x1234 -> busy=1 for 10 cycles, then lo=0x1234 unchanged. Also DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT in flight, MTHI 0xDEAD issued at busy cycle 2 -> ignored; hi = product high word at completion.
- Reset pulse at busy cycle 3 of DIV -> busy=0, hi=lo=0 immediately; no later write occurs.
- With MDU_MADD_EN: MTHI 0, MTLO 10, then MADD rs=3, rt=4 -> lo=22, hi=0. Without MDU_MADD_EN, the same sequence -> busy stays 0 and lo=10.
